// File: rtl/traffic_master_pkg.sv
// Shared types and constants for the traffic_master FIFO exerciser:
// FSM states, pattern mode encodings and per-width Galois LFSR taps.
package traffic_master_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_FINISH
  } state_t;

  typedef enum logic [1:0] {
    MODE_COUNTER = 2'd0,
    MODE_LFSR    = 2'd1,
    MODE_WALK    = 2'd2,
    MODE_ALT     = 2'd3
  } mode_t;

  localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
  localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

  function automatic logic [31:0] lfsr_taps(input int unsigned width);
    case (width)
      16:      return {16'h0000, LFSR_TAPS_16};
      32:      return LFSR_TAPS_32;
      default: return {24'h00_0000, LFSR_TAPS_8};
    endcase
  endfunction

endpackage

// File: rtl/traffic_master_if.sv
// FIFO-side bus of traffic_master: write/read strobes, data and flags.
interface traffic_master_if #(
  parameter int unsigned DATA_W = 8
);
  logic              wr_en_master;
  logic [DATA_W-1:0] data_in;
  logic              rd_en_master;
  logic [DATA_W-1:0] data_out;
  logic              full;
  logic              empty;

  modport master (
    output wr_en_master, data_in, rd_en_master,
    input  data_out, full, empty
  );

  modport slave (
    input  wr_en_master, data_in, rd_en_master,
    output data_out, full, empty
  );
endinterface

// File: rtl/traffic_master_pattern_gen.sv
// Pattern word generator: counter, Galois LFSR or walking-one.
// restart loads the mode's start value, advance steps one word.
module pattern_gen
  import traffic_master_pkg::*;
#(
  parameter int unsigned       DATA_W = 8,
  parameter logic [DATA_W-1:0] SEED   = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  mode_t             mode,
  input  logic              advance,
  input  logic              restart,
  output logic [DATA_W-1:0] word
);

  localparam logic [DATA_W-1:0] TAPS = DATA_W'(lfsr_taps(DATA_W));

  logic [DATA_W-1:0] start_val;
  logic [DATA_W-1:0] next_val;

  always_comb begin
    start_val = '0;
    next_val  = word + DATA_W'(1);
    case (mode)
      MODE_LFSR: begin
        start_val = SEED;
        next_val  = (word >> 1) ^ (word[0] ? TAPS : '0);
      end
      MODE_WALK: begin
        start_val = DATA_W'(1);
        next_val  = {word[DATA_W-2:0], word[DATA_W-1]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          word <= '0;
    else if (restart) word <= start_val;
    else if (advance) word <= next_val;
  end

endmodule

// File: rtl/traffic_master.sv
// FIFO traffic master: writes a burst of pattern words, reads them back.
// Define TRAFFIC_MASTER_CHECK_EN to compare read data and count mismatches.
module traffic_master
  import traffic_master_pkg::*;
#(
  parameter int unsigned       DATA_W = 8,
  parameter int unsigned       LEN_W  = 5,
  parameter logic [DATA_W-1:0] SEED   = '1
) (
  input  logic             clk_master,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [LEN_W-1:0] burst_len,
  traffic_master_if.master bus,
  output logic             busy,
  output logic             done,
  output logic [7:0]       err_count
);

  state_t            state_q, state_d;
  mode_t             mode_q, mode_sel;
  logic [LEN_W-1:0]  len_q, wr_cnt_q, rd_cnt_q;
  logic              start_ok, wr_en, rd_en;
  logic [DATA_W-1:0] wr_word;

  assign start_ok = start && (state_q == S_IDLE);
  // Generators restart on the accepting edge, so they need the live mode there.
  assign mode_sel = start_ok ? mode_t'(mode) : mode_q;

  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    case (state_q)
      S_IDLE:
        if (start) state_d = (burst_len == '0) ? S_FINISH : S_WRITE;
      S_WRITE:
        if (!bus.full) begin
          wr_en = 1'b1;
          if (wr_cnt_q + LEN_W'(1) == len_q) state_d = S_READ;
        end
      S_READ:
        if (!bus.empty) begin
          rd_en = 1'b1;
          if (rd_cnt_q + LEN_W'(1) == len_q) state_d = S_DRAIN;
        end
      S_DRAIN:  state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_master or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      mode_q   <= MODE_COUNTER;
      len_q    <= '0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        mode_q   <= mode_t'(mode);
        len_q    <= burst_len;
        wr_cnt_q <= '0;
        rd_cnt_q <= '0;
      end else begin
        if (wr_en) wr_cnt_q <= wr_cnt_q + LEN_W'(1);
        if (rd_en) rd_cnt_q <= rd_cnt_q + LEN_W'(1);
      end
    end
  end

  pattern_gen #(.DATA_W(DATA_W), .SEED(SEED)) u_wr_gen (
    .clk     (clk_master),
    .rst     (reset),
    .mode    (mode_sel),
    .advance (wr_en),
    .restart (start_ok),
    .word    (wr_word)
  );

  assign bus.wr_en_master = wr_en;
  assign bus.data_in      = wr_en ? wr_word : '0;
  assign bus.rd_en_master = rd_en;
  assign busy             = (state_q != S_IDLE);
  assign done             = (state_q == S_FINISH);

`ifdef TRAFFIC_MASTER_CHECK_EN
  logic              rd_pending;
  logic [DATA_W-1:0] exp_word;

  pattern_gen #(.DATA_W(DATA_W), .SEED(SEED)) u_exp_gen (
    .clk     (clk_master),
    .rst     (reset),
    .mode    (mode_sel),
    .advance (rd_pending),
    .restart (start_ok),
    .word    (exp_word)
  );

  always_ff @(posedge clk_master or posedge reset) begin
    if (reset) begin
      rd_pending <= 1'b0;
      err_count  <= '0;
    end else begin
      rd_pending <= rd_en;
      if (start_ok)
        err_count <= '0;
      else if (rd_pending && (bus.data_out != exp_word) && (err_count != 8'hFF))
        err_count <= err_count + 8'd1;
    end
  end
`else
  logic unused_data_out;
  assign unused_data_out = ^bus.data_out;
  assign err_count       = '0;
`endif

endmodule
